// File: rtl/s2cif_pkg.sv
// Shared types for the s2cif scenario interface: word/bit-count widths and the
// packed word record carried from the bit packer to the scenario push path.
package s2cif_pkg;
  localparam int S2CIF_WORD_W  = 32;
  localparam int S2CIF_NBITS_W = 6;

  typedef struct packed {
    logic [S2CIF_WORD_W-1:0]  data;
    logic [S2CIF_NBITS_W-1:0] nbits;
  } s2cif_word_t;
endpackage

// File: rtl/s2cif_sync_fifo.sv
// Small first-word-fall-through FIFO; dout shows the head whenever empty is low.
// A push into a full FIFO is accepted only if a pop frees the slot in the same cycle.
module s2cif_sync_fifo
  import s2cif_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = s2cif_word_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/s2cif_bit_packer.sv
// Packs the DUT's serial output LSB-first into 32-bit words, closing a word at 32 bits
// or on flush, and queues completed words in a FWFT FIFO behind a valid/ready port.
module s2cif_bit_packer
  import s2cif_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SAMPLE_DLY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_vld,
  input  logic                   bit_in,
  input  logic                   flush,
  output logic                   word_vld,
  input  logic                   word_rdy,
  output logic [31:0]            word_data,
  output logic [5:0]             word_nbits,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  logic s_vld;
  logic s_bit;
  logic s_flush;

  // flush travels with the samples so it still closes after the bit it accompanied
  generate
    if (SAMPLE_DLY == 0) begin : g_nodly
      assign s_vld   = bit_vld;
      assign s_bit   = bit_vld & bit_in;
      assign s_flush = flush;
    end else begin : g_dly
      logic [SAMPLE_DLY-1:0] vld_q;
      logic [SAMPLE_DLY-1:0] bit_q;
      logic [SAMPLE_DLY-1:0] flush_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q   <= '0;
          bit_q   <= '0;
          flush_q <= '0;
        end else begin
          vld_q[0]   <= bit_vld;
          bit_q[0]   <= bit_vld & bit_in;
          flush_q[0] <= flush;
          for (int i = 1; i < SAMPLE_DLY; i++) begin
            vld_q[i]   <= vld_q[i-1];
            bit_q[i]   <= bit_q[i-1];
            flush_q[i] <= flush_q[i-1];
          end
        end
      end
      assign s_vld   = vld_q[SAMPLE_DLY-1];
      assign s_bit   = bit_q[SAMPLE_DLY-1];
      assign s_flush = flush_q[SAMPLE_DLY-1];
    end
  endgenerate

  logic [5:0]  cnt_q;
  logic [5:0]  cnt_d;
  logic [31:0] sreg_q;
  logic [31:0] sreg_d;
  logic        close;
  logic        pop;
  logic        overflow_q;
  logic        fifo_empty;
  logic        fifo_full;
  s2cif_word_t push_word;
  s2cif_word_t head;

  always_comb begin
    cnt_d  = cnt_q;
    sreg_d = sreg_q;
    if (s_vld) begin
      sreg_d[cnt_q[4:0]] = s_bit;
      cnt_d              = cnt_q + 6'd1;
    end
  end

  assign close     = (cnt_d == 6'd32) | (s_flush & (cnt_d != '0));
  assign push_word = '{data: sreg_d, nbits: cnt_d};
  assign pop       = word_rdy & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sreg_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (close) begin
        cnt_q  <= '0;
        sreg_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        sreg_q <= sreg_d;
      end
      if (close & fifo_full & ~pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  s2cif_sync_fifo #(
    .DEPTH(DEPTH),
    .T    (s2cif_word_t)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (close),
    .din  (push_word),
    .pop  (pop),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full),
    .level(level)
  );

  // stale storage behind an empty head is never shown
  assign word_vld   = ~fifo_empty;
  assign word_data  = fifo_empty ? '0 : head.data;
  assign word_nbits = fifo_empty ? '0 : head.nbits;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_s2cif_bit_packer.sv
// Directed plus random stimulus for s2cif_bit_packer, checked every cycle against a
// queue-based model of the bit stream and the bounded word FIFO.
module tb_s2cif_bit_packer;
  import s2cif_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_vld;
  logic        bit_in;
  logic        flush;
  logic        word_vld;
  logic        word_rdy;
  logic [31:0] word_data;
  logic [5:0]  word_nbits;
  logic [2:0]  level;
  logic        overflow;

  s2cif_bit_packer #(.DEPTH(DEPTH), .SAMPLE_DLY(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_vld   (bit_vld),
    .bit_in    (bit_in),
    .flush     (flush),
    .word_vld  (word_vld),
    .word_rdy  (word_rdy),
    .word_data (word_data),
    .word_nbits(word_nbits),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  s2cif_word_t mq[$];
  bit          mbits[$];
  bit          movf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] ed;
    logic [5:0]  en;
    ed = '0;
    en = '0;
    if (mq.size() > 0) begin
      ed = mq[0].data;
      en = mq[0].nbits;
    end
    chk("word_vld", {31'd0, word_vld}, {31'd0, mq.size() > 0});
    chk("word_data", word_data, ed);
    chk("word_nbits", {26'd0, word_nbits}, {26'd0, en});
    chk("level", {29'd0, level}, 32'(mq.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_vld = 1'b0; bit_in = 1'b0; flush = 1'b0; word_rdy = 1'b0;
    @(posedge clk);
    mq.delete();
    mbits.delete();
    movf = 1'b0;
    #1;
    check_model();
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic b, input logic f, input logic r);
    s2cif_word_t w;
    rst = 1'b0; bit_vld = v; bit_in = v ? b : 1'bx; flush = f; word_rdy = r;
    @(posedge clk);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v) mbits.push_back(b);
    if (mbits.size() == 32 || (f && mbits.size() > 0)) begin
      w.data = '0;
      foreach (mbits[i]) w.data[i] = mbits[i];
      w.nbits = 6'(mbits.size());
      mbits.delete();
      if (mq.size() < DEPTH) mq.push_back(w);
      else movf = 1'b1;
    end
    #1;
    check_model();
  endtask

  task automatic push_bits(input logic [31:0] d, input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, d[i], 1'b0, r);
  endtask

  initial begin
    logic [31:0] d[5];
    logic [31:0] pat;

    do_reset();
    chk("rst_vld", {31'd0, word_vld}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);

    push_bits(32'hA5A5A5A5, 32, 1'b1);
    chk("a5_data", word_data, 32'hA5A5A5A5);
    chk("a5_nbits", {26'd0, word_nbits}, 32'd32);

    pat = 32'h0000000B;
    push_bits(pat, 5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush5_data", word_data, 32'h0000000B);
    chk("flush5_nbits", {26'd0, word_nbits}, 32'd5);

    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush3_data", word_data, 32'h00000005);
    chk("flush3_nbits", {26'd0, word_nbits}, 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_empty_vld", {31'd0, word_vld}, 32'd0);

    foreach (d[i]) d[i] = $urandom;
    for (int k = 0; k < 5; k++) push_bits(d[k], 32, 1'b0);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_head", word_data, d[0]);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", {31'd0, word_vld}, 32'd0);

    do_reset();
    for (int k = 0; k < 4; k++) push_bits($urandom, 32, 1'b0);
    pat = $urandom;
    push_bits(pat, 31, 1'b0);
    step(1'b1, pat[31], 1'b0, 1'b1);
    chk("fullpp_level", {29'd0, level}, 32'd4);
    chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1);

    push_bits($urandom, 17, 1'b1);
    do_reset();
    chk("midrst_level", {29'd0, level}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_vld", {31'd0, word_vld}, 32'd0);
    pat = $urandom;
    push_bits(pat, 32, 1'b1);
    chk("clean_data", word_data, pat);
    chk("clean_nbits", {26'd0, word_nbits}, 32'd32);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
